// File: rtl/adc_sample_buffer.sv
// Paced Avalon-MM reader for the MAX10 ADC slave.
// Captured samples land in a FWFT FIFO drained by host logic.
module adc_sample_buffer #(
  parameter int DEPTH   = 256,
  parameter int AW      = 10,
  parameter int DW      = 16,
  parameter int SBITS   = 12,
  parameter int TIMEOUT = 1023,
  localparam int PW = $clog2(DEPTH),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [15:0]   n_samples,
  input  logic [15:0]   period,
  input  logic [AW-1:0] adc_addr,
  output logic [AW-1:0] m_address,
  output logic          m_read,
  output logic          m_burstcount,
  input  logic [DW-1:0] m_readdata,
  input  logic          m_waitrequest,
  input  logic          m_readdatavalid,
  input  logic          s_pop,
  output logic [DW-1:0] s_data,
  output logic          s_empty,
  output logic [PW:0]   s_count,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic          timeout,
  input  logic          clear_flags
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_POST,
    S_PACE
  } state_t;

  localparam logic [PW:0]   FULL   = (PW + 1)'(DEPTH);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic [15:0]   r_n;
  logic [15:0]   r_period;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_cnt;
  logic [15:0]   r_pace;
  logic [TW-1:0] r_tmo;
  logic          r_stop;
  logic          r_done;
  logic          r_ovf;
  logic          r_tmo_flag;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  logic          w_in_rw;
  logic          w_cap;
  logic          w_tmo_hit;
  logic          w_stop;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [DW-1:0] w_sample;
  logic          w_unused_hi;

  assign w_in_rw   = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_cap     = w_in_rw && m_readdatavalid;
  assign w_tmo_hit = w_in_rw && !m_readdatavalid && (r_tmo == TO_MAX);
  assign w_stop    = r_stop || stop;
  assign w_full    = (r_count == FULL);
  assign w_empty   = (r_count == '0);
  assign w_pop     = s_pop && !w_empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts.
  assign w_push    = w_cap && (!w_full || w_pop);
  assign w_drop    = w_cap && w_full && !w_pop;
  assign w_sample  = {{(DW - SBITS){1'b0}}, m_readdata[SBITS-1:0]};
  assign w_unused_hi = &{1'b0, m_readdata[DW-1:SBITS]};

  assign m_read       = (r_state == S_REQ);
  assign m_address    = r_addr;
  assign m_burstcount = 1'b1;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign overflow     = r_ovf;
  assign timeout      = r_tmo_flag;
  assign s_data       = r_mem[r_rptr];
  assign s_empty      = w_empty;
  assign s_count      = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_period <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_pace   <= '0;
      r_tmo    <= '0;
      r_stop   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop && r_state != S_IDLE) r_stop <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n      <= n_samples;
            r_period <= period;
            r_addr   <= adc_addr;
            r_cnt    <= '0;
            r_tmo    <= '0;
            r_stop   <= 1'b0;
            r_state  <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          if (m_readdatavalid) begin
            r_cnt   <= r_cnt + 16'd1;
            r_state <= S_POST;
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (r_state == S_REQ && !m_waitrequest) r_state <= S_WAIT;
          end
        end
        S_POST: begin
          if (w_stop || (r_n != 16'd0 && r_cnt == r_n)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (r_period == 16'd0) begin
            r_tmo   <= '0;
            r_state <= S_REQ;
          end else begin
            r_pace  <= '0;
            r_state <= S_PACE;
          end
        end
        S_PACE: begin
          if (w_stop) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (r_pace == r_period - 16'd1) begin
            r_tmo   <= '0;
            r_state <= S_REQ;
          end else begin
            r_pace <= r_pace + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf      <= 1'b0;
      r_tmo_flag <= 1'b0;
    end else begin
      r_ovf      <= w_drop || (r_ovf && !clear_flags);
      r_tmo_flag <= w_tmo_hit || (r_tmo_flag && !clear_flags);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wptr] <= w_sample;
  end

endmodule

// File: doc/adc_sample_buffer.md
Name: adc_sample_buffer

Overview:
- Avalon-MM master that sits directly downstream of the MAX10 ADC Avalon slave.
- Issues paced single-beat reads to the ADC, captures each returned sample into an internal first-word-fall-through (FWFT) FIFO, and presents the FIFO to the RPi-side host logic as a pop interface.
- Provides start/stop control, an N-sample or continuous capture mode, a read timeout, and sticky overflow/timeout flags.

Parameters:
- DEPTH, 256, FIFO entries; power of 2, minimum 4.
- AW, 10, Avalon master address width.
- DW, 16, Avalon data width.
- SBITS, 12, valid sample bits taken from m_readdata[SBITS-1:0].
- TIMEOUT, 1023, maximum cycles to wait for m_readdatavalid.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins capture when IDLE, ignored otherwise.
- stop  in  1  one-cycle pulse; ends capture after any outstanding read.
- n_samples  in  16  samples per capture, sampled on start; 0 = continuous.
- period  in  16  idle cycles between reads, sampled on start.
- adc_addr  in  AW  address driven on m_address, sampled on start.
- m_address  out  AW  Avalon read address.
- m_read  out  1  Avalon read request.
- m_burstcount  out  1  constant 1.
- m_readdata  in  DW  Avalon read data.
- m_waitrequest  in  1  Avalon slave stall.
- m_readdatavalid  in  1  Avalon read data valid.
- s_pop  in  1  pops the FIFO head.
- s_data  out  DW  FIFO head: zero-extended sample; valid while !s_empty.
- s_empty  out  1  FIFO empty.
- s_count  out  log2(DEPTH)+1  FIFO occupancy.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on return to IDLE after a capture.
- overflow  out  1  sticky; a sample was dropped because the FIFO was full.
- timeout  out  1  sticky; a read timed out.
- clear_flags  in  1  clears overflow and timeout.

Behaviour:
- Reset values: m_read=0, m_address=0, s_empty=1, s_count=0, busy=0, done=0, overflow=0, timeout=0, FIFO pointers=0, state=IDLE. Reset takes priority over all inputs.
- Reset mid-transaction: m_read is low from the next edge; late m_readdatavalid is ignored because the state is IDLE.
- IDLE: on start, latch n_samples, period and adc_addr, clear the sample counter, go to REQ. There is no pacing before the first read.
- REQ: m_read=1 and m_address=latched address. Hold until m_waitrequest=0, then go to WAIT. If m_readdatavalid=1 in REQ (slave accepted while stalled), capture the sample and go to POST the same cycle. The slave samples read only in its idle state, so m_read must stay high until acceptance or data.
- WAIT: m_read=0. On m_readdatavalid, capture the sample and go to POST.
- Timeout counter: runs in REQ and WAIT. On reaching TIMEOUT: m_read=0, set timeout, end the capture (done pulse, go to IDLE). No sample is pushed.
- Capture: push m_readdata[SBITS-1:0], zero-extended to DW.
  - If the FIFO is full, drop the sample and set overflow.
  - The sample counter increments whether the sample is pushed or dropped.
- POST:
  - If stop has been seen since start, or the counter equals n_samples (n_samples≠0), pulse done and go to IDLE.
  - Else if period=0, go to REQ.
  - Else go to PACE.
- PACE: count period cycles, then go to REQ. A stop seen here goes to IDLE with a done pulse.
- stop is latched in any busy state. A stop in REQ/WAIT never abandons the Avalon transaction: that read completes and its sample is pushed.
- start while busy is ignored.
- FIFO is FWFT: s_data reflects the head combinationally from registered storage.
  - s_pop while empty is ignored.
  - Simultaneous push and pop on a full FIFO: the pop frees the slot, so the push succeeds and overflow is not set.
  - Simultaneous push and pop otherwise: s_count unchanged.
  - Pointers wrap modulo DEPTH.
- clear_flags and a new flag event in the same cycle: the flag stays set.
- Throughput: at most one read outstanding. Minimum read-to-read spacing is REQ + WAIT + POST + period cycles.

Test Plan:
- Slave returns 0x0000, 0x0001, 0x0002…; start with n_samples=4, period=0 -> exactly 4 m_read assertions, FIFO holds 0,1,2,3, s_count=4, done pulses once, busy drops.
- m_readdata=0xFABC -> s_data=0x0ABC.
- DEPTH=4, n_samples=6, no pops -> s_count=4, s_data=first sample, overflow=1. Then clear_flags -> overflow=0.
- Slave never asserts m_readdatavalid and holds m_waitrequest=1 -> m_read high for TIMEOUT cycles then low, timeout=1, done pulses, FIFO empty.
- n_samples=0, period=10, stop asserted while in WAIT -> that read completes, its sample is pushed, no further m_read, done pulses. Consecutive m_read rising edges are ≥13 cycles apart.
- Reset asserted while m_read=1 -> m_read=0 and all outputs at reset values next cycle. A later m_readdatavalid pushes nothing (s_count stays 0).
